// File: rtl/uart_rx.sv
// UART receiver: start/8 data (LSB first)/optional parity/stop framing,
// Prescale-times oversampling with a 3-sample majority vote per bit.
// RX_IN is treated as already synchronous to clk (bit timing counts from
// the first clk edge that sees it low).
module uart_rx #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      DATA_VALID,
    output logic                      PAR_ERR,
    output logic                      STP_ERR,
    output logic                      Busy
);

    localparam int unsigned PW        = PRESCALE_WIDTH;
    localparam int unsigned BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e                 state_q,      state_d;
    logic [PW-1:0]          edge_cnt_q,   edge_cnt_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q,    bit_cnt_d;
    logic [PW-1:0]          presc_q,      presc_d;
    logic                   par_en_q,     par_en_d;
    logic                   par_typ_q,    par_typ_d;
    logic [DATA_WIDTH-1:0]  shift_q,      shift_d;
    logic [2:0]             samp_q,       samp_d;
    logic                   par_mis_q,    par_mis_d;
    logic                   armed_q,      armed_d;
    logic [DATA_WIDTH-1:0]  p_data_q,     p_data_d;
    logic                   data_valid_q, data_valid_d;
    logic                   par_err_q,    par_err_d;
    logic                   stp_err_q,    stp_err_d;
    logic                   busy_q,       busy_d;

    logic [PW-1:0]          half_c;
    logic                   bit_end_c;
    logic                   sample_bit_c;
    logic                   exp_par_c;

    // Bit-timing helpers derived from the prescale latched at start detection
    assign half_c    = {1'b0, presc_q[PW-1:1]};
    assign bit_end_c = (edge_cnt_q == presc_q - PW'(1));
    assign exp_par_c = par_typ_q ? (^shift_q) : ~(^shift_q);

    // Capture the three mid-bit samples; the vote uses the updated set so the
    // last sample may coincide with the bit-end cycle (Prescale = 4)
    always_comb begin
        samp_d = samp_q;
        if (state_q != S_IDLE) begin
            if (edge_cnt_q == half_c - PW'(1)) samp_d[0] = RX_IN;
            if (edge_cnt_q == half_c)          samp_d[1] = RX_IN;
            if (edge_cnt_q == half_c + PW'(1)) samp_d[2] = RX_IN;
        end
        sample_bit_c = (samp_d[0] & samp_d[1]) | (samp_d[0] & samp_d[2]) |
                       (samp_d[1] & samp_d[2]);
    end

    // Next-state and registered-output logic for the frame FSM
    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        presc_d      = presc_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        shift_d      = shift_q;
        par_mis_d    = par_mis_q;
        armed_d      = armed_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        if (state_q != S_IDLE) begin
            edge_cnt_d = bit_end_c ? '0 : edge_cnt_q + PW'(1);
        end

        case (state_q)
            S_IDLE: begin
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                if (RX_IN) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    // The detecting cycle is edge 0 of the start bit
                    state_d    = S_START;
                    edge_cnt_d = PW'(1);
                    presc_d    = Prescale;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    par_mis_d  = 1'b0;
                end
            end
            S_START: begin
                if (bit_end_c) begin
                    state_d = sample_bit_c ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end_c) begin
                    shift_d[bit_cnt_q] = sample_bit_c;
                    if (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_end_c) begin
                    par_mis_d = (sample_bit_c != exp_par_c);
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end_c) begin
                    state_d = S_IDLE;
                    // A low stop bit (break) must see the line high before re-arming
                    armed_d = sample_bit_c;
                    if (sample_bit_c && !par_mis_q) begin
                        data_valid_d = 1'b1;
                        p_data_d     = shift_q;
                    end else begin
                        par_err_d = par_mis_q;
                        stp_err_d = ~sample_bit_c;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            presc_q      <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            shift_q      <= '0;
            samp_q       <= '0;
            par_mis_q    <= 1'b0;
            armed_q      <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            presc_q      <= presc_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            shift_q      <= shift_d;
            samp_q       <= samp_d;
            par_mis_q    <= par_mis_d;
            armed_q      <= armed_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
            busy_q       <= busy_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign DATA_VALID = data_valid_q;
    assign PAR_ERR    = par_err_q;
    assign STP_ERR    = stp_err_q;
    assign Busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames, hand-written corner
// sequences and a random back-to-back transmitter stream, all checked
// through a scoreboard of expected strobes.
module tb_uart_rx;

    localparam int unsigned DW = 8;
    localparam int unsigned PW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          RX_IN;
    logic [PW-1:0] Prescale;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic [DW-1:0] P_DATA;
    logic          DATA_VALID;
    logic          PAR_ERR;
    logic          STP_ERR;
    logic          Busy;

    uart_rx #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
        .clk        (clk),
        .reset      (reset),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR),
        .Busy       (Busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          dv;
        logic          pe;
        logic          se;
        logic [DW-1:0] pdata;
    } exp_t;

    typedef struct {
        logic [DW-1:0] data;
        bit            pen;
        bit            ptyp;
        bit            flip;
        bit            stop_bad;
        int            presc;
        bit            dv;
        bit            pe;
        bit            se;
    } vec_t;

    exp_t          exp_q[$];
    int            n_chk = 0;
    int            n_pass = 0;
    logic [DW-1:0] model_pdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic push_exp(input bit dv, input bit pe, input bit se, input logic [DW-1:0] d);
        exp_t e;
        if (dv) model_pdata = d;
        e.dv    = dv;
        e.pe    = pe;
        e.se    = se;
        e.pdata = model_pdata;
        exp_q.push_back(e);
    endtask

    // Transmitter model: drives one frame, starting at a falling clk edge
    task automatic send_frame(input logic [DW-1:0] d, input bit pen, input bit ptyp,
                              input bit flip, input bit stop_bad, input int p,
                              input bit noise, input bit scramble);
        logic [11:0] bits;
        int          nb;
        int          npos;
        bits    = '0;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        nb = 9;
        if (pen) begin
            bits[nb] = (ptyp ? (^d) : ~(^d)) ^ flip;
            nb++;
        end
        bits[nb] = ~stop_bad;
        nb++;
        Prescale = PW'(p);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        for (int b = 0; b < nb; b++) begin
            npos = p / 2 - 1 + int'($urandom_range(0, 2));
            for (int j = 0; j < p; j++) begin
                RX_IN = bits[b] ^ (noise && (j == npos));
                if (scramble && b == 1 && j == 0) begin
                    Prescale = PW'(p + 8);
                    PAR_EN   = ~pen;
                    PAR_TYP  = ~ptyp;
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int idle);
        push_exp(v.dv, v.pe, v.se, v.data);
        send_frame(v.data, v.pen, v.ptyp, v.flip, v.stop_bad, v.presc, 1'b0, 1'b0);
        RX_IN = 1'b1;
        repeat (idle) @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: every strobe must match the oldest expected frame result
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && (DATA_VALID || PAR_ERR || STP_ERR)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {29'd0, DATA_VALID, PAR_ERR, STP_ERR}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("strobes", {29'd0, DATA_VALID, PAR_ERR, STP_ERR}, {29'd0, e.dv, e.pe, e.se});
                    check("p_data", 32'(P_DATA), 32'(e.pdata));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        int   busy_cnt;
        logic [DW-1:0] d;

        vecs[0] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 16, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1,  8, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'h5A, 1'b1, 1'b0, 1'b1, 1'b1,  8, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b0,  4, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 62, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0,  6, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, 10, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{8'h80, 1'b0, 1'b0, 1'b0, 1'b0,  4, 1'b1, 1'b0, 1'b0};

        reset    = 1'b0;
        RX_IN    = 1'b1;
        Prescale = PW'(8);
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {19'd0, P_DATA, DATA_VALID, PAR_ERR, STP_ERR, Busy}, 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("busy_idle", 32'(Busy), 32'd0);

        // Timed frame: 0xA5, Prescale 8, no parity
        push_exp(1'b1, 1'b0, 1'b0, 8'hA5);
        busy_cnt = 0;
        fork
            send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b0);
            begin
                wait (RX_IN == 1'b0);
                for (int k = 0; k <= 80; k++) begin
                    @(negedge clk);
                    if (Busy) busy_cnt++;
                    if (k == 0)  check("busy_rise", 32'(Busy), 32'd1);
                    if (k == 78) check("dv_early", 32'(DATA_VALID), 32'd0);
                    if (k == 79) begin
                        check("dv_at_80", 32'(DATA_VALID), 32'd1);
                        check("p_data_a5", 32'(P_DATA), 32'h A5);
                        check("busy_fall", 32'(Busy), 32'd0);
                    end
                    if (k == 80) check("dv_one_cycle", 32'(DATA_VALID), 32'd0);
                end
            end
        join
        check("busy_cycles", 32'(busy_cnt), 32'd79);
        RX_IN = 1'b1;
        wait_drain("drain_timed");

        // Table of frames with parity/stop variations
        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], 3);
            wait_drain("drain_vec");
            check("busy_after_vec", 32'(Busy), 32'd0);
        end

        // Start glitch: two low cycles, FSM gives up after one bit time
        Prescale = PW'(8);
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        @(negedge clk);
        check("glitch_busy", 32'(Busy), 32'd1);
        @(negedge clk);
        RX_IN = 1'b1;
        repeat (5) @(negedge clk);
        check("glitch_busy_n6", 32'(Busy), 32'd1);
        @(negedge clk);
        check("glitch_busy_n7", 32'(Busy), 32'd0);
        repeat (4) @(negedge clk);
        check("glitch_no_pending", 32'(exp_q.size()), 32'd0);

        // Break: line held low; one stop error, then no restart until high
        Prescale = PW'(8);
        PAR_EN   = 1'b0;
        push_exp(1'b0, 1'b0, 1'b1, 8'h00);
        RX_IN    = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (k >= 100 && Busy) busy_cnt++;
        end
        check("break_no_restart", 32'(busy_cnt), 32'd0);
        RX_IN = 1'b1;
        repeat (4) @(negedge clk);
        wait_drain("drain_break");

        // Mid-frame asynchronous reset during data bit 4, then a clean frame
        d     = 8'h6E;
        RX_IN = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            RX_IN = d[i];
            repeat (8) @(negedge clk);
        end
        RX_IN = d[4];
        repeat (4) @(negedge clk);
        check("busy_before_reset", 32'(Busy), 32'd1);
        reset = 1'b0;
        #2;
        check("async_reset", {19'd0, P_DATA, DATA_VALID, PAR_ERR, STP_ERR, Busy}, 32'd0);
        model_pdata = '0;
        RX_IN = 1'b1;
        @(negedge clk);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        push_exp(1'b1, 1'b0, 1'b0, 8'h81);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b0);
        RX_IN = 1'b1;
        wait_drain("drain_after_reset");

        // Random back-to-back stream with sampling noise and mid-frame config changes
        for (int n = 0; n < 500; n++) begin
            logic [DW-1:0] rd;
            bit            pen;
            bit            ptyp;
            rd   = DW'($urandom_range(0, 255));
            pen  = 1'($urandom_range(0, 1));
            ptyp = 1'($urandom_range(0, 1));
            push_exp(1'b1, 1'b0, 1'b0, rd);
            send_frame(rd, pen, ptyp, 1'b0, 1'b0, 8, 1'b1, 1'b1);
        end
        RX_IN = 1'b1;
        wait_drain("drain_stream");
        repeat (20) @(negedge clk);
        check("final_busy", 32'(Busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
